// File: rtl/uart_tx_byte_feeder_pkg.sv
// uart_tx_byte_feeder_pkg: launch FSM states and default FIFO geometry
package uart_tx_byte_feeder_pkg;
   localparam int DEPTH_DEF  = 16;
   localparam int ADDR_W_DEF = 4;
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_ACT  = 2'd2,
      WAIT_DONE = 2'd3
   } feed_state_t;
endpackage

// File: rtl/sync_byte_fifo.sv
// sync_byte_fifo: byte FIFO with registered count/full/empty and a rejected-write pulse
module sync_byte_fifo
   import uart_tx_byte_feeder_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              flush_in,
   input  logic              wr_en_in,
   input  logic [7:0]        wr_data_in,
   input  logic              rd_en_in,
   output logic [7:0]        rd_data_op,
   output logic              full_op,
   output logic              empty_op,
   output logic [ADDR_W:0]   count_op,
   output logic              overflow_op
);
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              wr, rd;
   logic [ADDR_W:0]   count_nx;
   // flush beats a simultaneous write so the FIFO really ends up empty
   assign wr         = wr_en_in && !full_op && !flush_in;
   assign rd         = rd_en_in && !empty_op;
   assign count_nx   = count_op + (ADDR_W+1)'(wr) - (ADDR_W+1)'(rd);
   assign rd_data_op = mem[rd_ptr];
   always_ff @(posedge clk_in)
      if (wr) mem[wr_ptr] <= wr_data_in;
   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_op    <= '0;
         empty_op    <= 1'b1;
         full_op     <= 1'b0;
         overflow_op <= 1'b0;
      end else begin
         overflow_op <= wr_en_in && full_op;
         if (flush_in) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_op <= '0;
            empty_op <= 1'b1;
            full_op  <= 1'b0;
         end else begin
            wr_ptr   <= wr_ptr + ADDR_W'(wr);
            rd_ptr   <= rd_ptr + ADDR_W'(rd);
            count_op <= count_nx;
            empty_op <= count_nx == '0;
            full_op  <= count_nx == (ADDR_W+1)'(DEPTH);
         end
      end
endmodule

// File: rtl/uart_tx_byte_feeder.sv
// uart_tx_byte_feeder: buffers bytes and hands them one at a time to a UART transmitter
module uart_tx_byte_feeder
   import uart_tx_byte_feeder_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              flush_in,
   input  logic              wr_en_in,
   input  logic [7:0]        wr_data_in,
   output logic              full_op,
   output logic              empty_op,
   output logic [ADDR_W:0]   count_op,
   output logic              overflow_op,
   output logic              busy_op,
   output logic              tx_datav_op,
   output logic [7:0]        tx_byte_op,
   input  logic              tx_active_in,
   input  logic              tx_done_in
);
   feed_state_t state;
   logic        pop;
   logic [7:0]  head;
   // waiting for tx_active low keeps us off a transmitter still finishing a byte
   assign pop = state == IDLE && !empty_op && !tx_active_in;
   sync_byte_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) fifo (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .flush_in    (flush_in),
      .wr_en_in    (wr_en_in),
      .wr_data_in  (wr_data_in),
      .rd_en_in    (pop),
      .rd_data_op  (head),
      .full_op     (full_op),
      .empty_op    (empty_op),
      .count_op    (count_op),
      .overflow_op (overflow_op)
   );
   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) begin
         state       <= IDLE;
         busy_op     <= 1'b0;
         tx_datav_op <= 1'b0;
         tx_byte_op  <= 8'h00;
      end else
         case (state)
            IDLE:
               if (pop) begin
                  state       <= LAUNCH;
                  tx_byte_op  <= head;
                  tx_datav_op <= 1'b1;
                  busy_op     <= 1'b1;
               end
            LAUNCH: begin
               state       <= WAIT_ACT;
               tx_datav_op <= 1'b0;
            end
            WAIT_ACT:
               if (tx_done_in) begin
                  state   <= IDLE;
                  busy_op <= 1'b0;
               end else if (tx_active_in)
                  state <= WAIT_DONE;
            WAIT_DONE:
               if (tx_done_in) begin
                  state   <= IDLE;
                  busy_op <= 1'b0;
               end
            default: begin
               state       <= IDLE;
               tx_datav_op <= 1'b0;
               busy_op     <= 1'b0;
            end
         endcase
endmodule
